esdi_command_sequencer: RTL and testbench
=========================================

// Module: esdi_command_sequencer
// PURPOSE
//  Serialises one 16-bit ESDI command and odd parity onto command_data using
//  the transfer_req/transfer_ack bit handshake. Optionally deserialises the
//  drive's 17-bit status reply from confstat_data, then waits for
//  command_complete. Sits inside soc_bd between the CPU-facing register
//  interface and the drive pins; the top level inverts req/data to the
//  active-low bus.
// PARAMETERS
//  SETUP_CYCLES    4        aclk cycles command_data is held stable before req rises (>=1)
//  SYNC_STAGES     2        flop depth of input synchronisers (>=2)
//  TIMEOUT_CYCLES  1000000  per-handshake-phase watchdog limit (ESDI_CMD_TIMEOUT_EN only)
// PORTS
//  aclk                   in   1   sole clock
//  aresetn                in   1   async active-low reset
//  cmd_valid              in   1   command request
//  cmd_ready              out  1   high in IDLE only; accept on valid&ready
//  cmd_data               in   16  command word, sent MSB first
//  cmd_expect_status      in   1   1 = read 17-bit status reply after command
//  rsp_valid              out  1   result available; held until rsp_ready
//  rsp_ready              in   1   result consumed
//  rsp_status             out  16  received status word (0 if none requested)
//  rsp_parity_err         out  1   received status failed odd parity
//  rsp_timeout            out  1   watchdog expired (0 when feature compiled out)
//  busy                   out  1   state != IDLE
//  esdi_transfer_req      out  1   active-high req to drive
//  esdi_command_data      out  1   active-high serial command bit
//  esdi_transfer_ack      in   1   async from drive, active high
//  esdi_confstat_data     in   1   async serial status bit
//  esdi_command_complete  in   1   async, active high
// BEHAVIOUR
//  - Reset: IDLE, all outputs 0 except cmd_ready=1; bit counter and shift regs 0.
//  - Drive inputs pass through SYNC_STAGES flops; FSM uses synced values only.
//    confstat_data shares ack's sync depth so both arrive aligned.
//  - Accept: latch {cmd_data, p} where p = ~^cmd_data (total ones odd).
//    Bit count = 17. cmd_ready drops the cycle after accept.
//  - FSM states:
//    IDLE      -> CMD_SETUP on accept.
//    CMD_SETUP data = current bit, req=0; after SETUP_CYCLES -> CMD_REQ.
//    CMD_REQ   req=1, data held; on ack_s=1 -> CMD_REL.
//    CMD_REL   req=0, data held; on ack_s=0: if bits remain, shift, -> CMD_SETUP;
//              else -> STS_REQ if expect_status, else WAIT_CC.
//    STS_REQ   req=1, command_data=0; on first ack_s=1 shift confstat_s into
//              17-bit reg (MSB first) -> STS_REL.
//    STS_REL   req=0; on ack_s=0: 17 bits taken -> WAIT_CC, else -> STS_REQ.
//    WAIT_CC   on command_complete_s=1 -> DONE.
//    DONE      rsp_valid=1; outputs stable; on rsp_ready -> IDLE (cmd_ready=1 next cycle).
//  - rsp_status = bits[16:1] of the status reg; rsp_parity_err = ~^(all 17 bits).
//  - Exactly one bit per req/ack cycle. req never rises while ack_s=1 (CMD_SETUP and
//    STS_REQ entry require ack_s=0, already guaranteed by the REL exit).
//  - cmd_valid while busy: ignored (not accepted). rsp fields update only on DONE entry.
//  - aresetn mid-transfer: immediate return to reset state; req deasserts asynchronously.
// CONFIGURATION
//  ESDI_CMD_TIMEOUT_EN defined: a counter clears on every state change and increments
//   in CMD_REQ, CMD_REL, STS_REQ, STS_REL and WAIT_CC. At TIMEOUT_CYCLES: req=0,
//   -> DONE with rsp_timeout=1, rsp_status=0, rsp_parity_err=0.
//  Undefined: no counter logic; FSM waits indefinitely; rsp_timeout tied 0.
// TESTING
//  1 cmd 16'h0001, no status, drive model acks after 3 cycles, cc after last bit ->
//    17 req pulses, bits 0x0001 MSB first then parity 0; rsp_valid, status 0, err 0.
//  2 cmd 16'h0000 -> parity bit sent = 1; cmd 16'hFFFF -> parity bit = 1;
//    cmd 16'h0003 -> parity bit = 1.
//  3 cmd with status, drive returns 16'hA5C3 + parity 1 -> rsp_status=16'hA5C3,
//    rsp_parity_err=0; same word with parity 0 -> rsp_parity_err=1.
//  4 cmd_valid pulsed again while busy, rsp_ready held low 10 cycles -> second cmd
//    not accepted; rsp_valid held stable 10 cycles; cmd_ready rises after rsp_ready.
//  5 TIMEOUT_CYCLES=100, EN defined, drive never acks -> req high 100 cycles, then
//    req=0, rsp_valid with rsp_timeout=1; EN undefined -> req stays high, busy=1.
//  6 aresetn low during bit 7 of command -> req=0 and cmd_ready=1 out of reset;
//    new command then completes normally with all 17 bits.

Source files
------------

// File: rtl/esdi_command_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : esdi_command_sequencer                                           |
// | Brief   : Serialises a 16-bit ESDI command plus odd parity over the        |
// |           transfer_req/transfer_ack handshake, optionally collects the     |
// |           17-bit status reply, then waits for command_complete.            |
// |           Optional watchdog: define ESDI_CMD_TIMEOUT_EN.                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module esdi_command_sequencer #(
  parameter int SETUP_CYCLES   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic        cmd_expect_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_status,
  output logic        rsp_parity_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        esdi_transfer_req,
  output logic        esdi_command_data,
  input  logic        esdi_transfer_ack,
  input  logic        esdi_confstat_data,
  input  logic        esdi_command_complete
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CMD_SETUP = 3'd1;
  localparam logic [2:0] S_CMD_REQ   = 3'd2;
  localparam logic [2:0] S_CMD_REL   = 3'd3;
  localparam logic [2:0] S_STS_REQ   = 3'd4;
  localparam logic [2:0] S_STS_REL   = 3'd5;
  localparam logic [2:0] S_WAIT_CC   = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);

  if (SETUP_CYCLES < 1) begin : g_chk_setup
    $error("SETUP_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] sts_sync_q, sts_sync_d;
  logic [SYNC_STAGES-1:0] cc_sync_q, cc_sync_d;
  logic                   ack_s, sts_s, cc_s;

  logic [2:0]         state_q, state_d;
  logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [4:0]         bits_left_q, bits_left_d;
  logic [16:0]        cmd_sr_q, cmd_sr_d;
  logic [16:0]        sts_sr_q, sts_sr_d;
  logic [4:0]         sts_cnt_q, sts_cnt_d;
  logic               expect_q, expect_d;
  logic [15:0]        rsp_status_q, rsp_status_d;
  logic               rsp_parity_err_q, rsp_parity_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic setup_done;
  logic last_bit;
  logic timeout_hit;

  // Status data shares the ack synchroniser depth so a bit lines up with its ack.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], esdi_transfer_ack};
    sts_sync_d = {sts_sync_q[SYNC_STAGES-2:0], esdi_confstat_data};
    cc_sync_d  = {cc_sync_q[SYNC_STAGES-2:0], esdi_command_complete};
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign sts_s = sts_sync_q[SYNC_STAGES-1];
  assign cc_s  = cc_sync_q[SYNC_STAGES-1];

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign setup_done = (setup_cnt_q == SETUP_W'(SETUP_CYCLES - 1));
  assign last_bit   = (bits_left_q == 5'd1);

`ifdef ESDI_CMD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_active;

  assign wd_active = (state_q == S_CMD_REQ) || (state_q == S_CMD_REL) ||
                     (state_q == S_STS_REQ) || (state_q == S_STS_REL) ||
                     (state_q == S_WAIT_CC);
  assign timeout_hit = wd_active && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (wd_active && (state_d == state_q)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack_sync_q       <= '0;
      sts_sync_q       <= '0;
      cc_sync_q        <= '0;
      state_q          <= S_IDLE;
      setup_cnt_q      <= '0;
      bits_left_q      <= '0;
      cmd_sr_q         <= '0;
      sts_sr_q         <= '0;
      sts_cnt_q        <= '0;
      expect_q         <= 1'b0;
      rsp_status_q     <= '0;
      rsp_parity_err_q <= 1'b0;
      rsp_timeout_q    <= 1'b0;
    end else begin
      ack_sync_q       <= ack_sync_d;
      sts_sync_q       <= sts_sync_d;
      cc_sync_q        <= cc_sync_d;
      state_q          <= state_d;
      setup_cnt_q      <= setup_cnt_d;
      bits_left_q      <= bits_left_d;
      cmd_sr_q         <= cmd_sr_d;
      sts_sr_q         <= sts_sr_d;
      sts_cnt_q        <= sts_cnt_d;
      expect_q         <= expect_d;
      rsp_status_q     <= rsp_status_d;
      rsp_parity_err_q <= rsp_parity_err_d;
      rsp_timeout_q    <= rsp_timeout_d;
    end
  end

  // Leaving setup also waits for ack_s low so req can never rise into a held ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cmd_valid) state_d = S_CMD_SETUP;
      S_CMD_SETUP: if (setup_done && !ack_s) state_d = S_CMD_REQ;
      S_CMD_REQ:   if (ack_s) state_d = S_CMD_REL;
      S_CMD_REL: begin
        if (!ack_s) begin
          if (!last_bit)     state_d = S_CMD_SETUP;
          else if (expect_q) state_d = S_STS_REQ;
          else               state_d = S_WAIT_CC;
        end
      end
      S_STS_REQ:   if (ack_s) state_d = S_STS_REL;
      S_STS_REL:   if (!ack_s) state_d = (sts_cnt_q == 5'd17) ? S_WAIT_CC : S_STS_REQ;
      S_WAIT_CC:   if (cc_s) state_d = S_DONE;
      S_DONE:      if (rsp_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    setup_cnt_d      = '0;
    bits_left_d      = bits_left_q;
    cmd_sr_d         = cmd_sr_q;
    sts_sr_d         = sts_sr_q;
    sts_cnt_d        = sts_cnt_q;
    expect_d         = expect_q;
    rsp_status_d     = rsp_status_q;
    rsp_parity_err_d = rsp_parity_err_q;
    rsp_timeout_d    = rsp_timeout_q;

    if (state_q == S_CMD_SETUP) begin
      setup_cnt_d = setup_done ? setup_cnt_q : setup_cnt_q + 1'b1;
    end

    if (accept) begin
      cmd_sr_d    = {cmd_data, ~^cmd_data};
      bits_left_d = 5'd17;
      sts_sr_d    = '0;
      sts_cnt_d   = '0;
      expect_d    = cmd_expect_status;
    end

    if ((state_q == S_CMD_REL) && !ack_s) begin
      bits_left_d = bits_left_q - 5'd1;
      if (!last_bit) begin
        cmd_sr_d = {cmd_sr_q[15:0], 1'b0};
      end
    end

    if ((state_q == S_STS_REQ) && ack_s) begin
      sts_sr_d  = {sts_sr_q[15:0], sts_s};
      sts_cnt_d = sts_cnt_q + 5'd1;
    end

    // Response fields are frozen except on the transition into DONE.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rsp_timeout_d    = timeout_hit;
      rsp_status_d     = timeout_hit ? 16'h0000 : sts_sr_q[16:1];
      rsp_parity_err_d = !timeout_hit && expect_q && ~(^sts_sr_q);
    end
  end

  always_comb begin
    cmd_ready         = (state_q == S_IDLE);
    busy              = (state_q != S_IDLE);
    rsp_valid         = (state_q == S_DONE);
    esdi_transfer_req = (state_q == S_CMD_REQ) || (state_q == S_STS_REQ);
    esdi_command_data = 1'b0;
    if ((state_q == S_CMD_SETUP) || (state_q == S_CMD_REQ) || (state_q == S_CMD_REL)) begin
      esdi_command_data = cmd_sr_q[16];
    end
    rsp_status     = rsp_status_q;
    rsp_parity_err = rsp_parity_err_q;
    rsp_timeout    = rsp_timeout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_esdi_command_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_esdi_command_sequencer                                        |
// | Brief   : Scoreboard bench with a behavioural ESDI drive model.            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_esdi_command_sequencer;

  localparam int TIMEOUT_CYCLES = 100;
  localparam int RSP_BUDGET     = 3000;

  typedef struct packed {
    logic [15:0] status;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic        cmd_expect_status = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_status;
  logic        rsp_parity_err;
  logic        rsp_timeout;
  logic        busy;
  logic        esdi_transfer_req;
  logic        esdi_command_data;
  logic        esdi_transfer_ack = 1'b0;
  logic        esdi_confstat_data = 1'b0;
  logic        esdi_command_complete = 1'b0;

  int   n_checks = 0;
  int   n_fails  = 0;
  bit   exp_bits[$];
  rsp_t exp_rsp[$];

  bit          drv_en = 1'b0;
  int          drv_total = 17;
  logic [16:0] drv_sts = '0;
  int          pulse_cnt = 0;

  esdi_command_sequencer #(
    .SETUP_CYCLES   (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_data              (cmd_data),
    .cmd_expect_status     (cmd_expect_status),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_status            (rsp_status),
    .rsp_parity_err        (rsp_parity_err),
    .rsp_timeout           (rsp_timeout),
    .busy                  (busy),
    .esdi_transfer_req     (esdi_transfer_req),
    .esdi_command_data     (esdi_command_data),
    .esdi_transfer_ack     (esdi_transfer_ack),
    .esdi_confstat_data    (esdi_confstat_data),
    .esdi_command_complete (esdi_command_complete)
  );

  always #5 aclk = ~aclk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive model: sees req, presents status bit if due, acks 3 cycles later,
  // drops ack 2 cycles after req falls, raises command_complete after the last pulse.
  initial begin : drive_model
    int k;
    forever begin
      @(negedge aclk);
      if (drv_en && aresetn && esdi_transfer_req && !esdi_transfer_ack) begin
        esdi_command_complete = 1'b0;
        if (pulse_cnt < 17) begin
          if (exp_bits.size() == 0) chk_val("unexpected_cmd_bit", 32'd1, 32'd0);
          else chk_val($sformatf("cmd_bit%0d", pulse_cnt), 32'(esdi_command_data), 32'(exp_bits.pop_front()));
        end else begin
          chk_val($sformatf("sts_phase_data%0d", pulse_cnt), 32'(esdi_command_data), 32'd0);
          if (pulse_cnt < drv_total) esdi_confstat_data = drv_sts[16 - (pulse_cnt - 17)];
        end
        repeat (3) @(negedge aclk);
        esdi_transfer_ack = 1'b1;
        pulse_cnt++;
        k = 0;
        while (esdi_transfer_req && k < 1000) begin
          @(negedge aclk);
          k++;
        end
        if (k >= 1000) chk_val("req_release_wait", 32'd1, 32'd0);
        repeat (2) @(negedge aclk);
        esdi_transfer_ack = 1'b0;
        if (pulse_cnt == drv_total) esdi_command_complete = 1'b1;
      end
    end
  end

  task automatic issue(input logic [15:0] data, input bit expect_sts);
    int k;
    k = 0;
    while (!cmd_ready && k < RSP_BUDGET) begin
      @(negedge aclk);
      k++;
    end
    if (k >= RSP_BUDGET) chk_val("cmd_ready_wait", 32'd0, 32'd1);
    cmd_data          = data;
    cmd_expect_status = expect_sts;
    cmd_valid         = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk_val("cmd_ready_drop", 32'(cmd_ready), 32'd0);
  endtask

  task automatic send_cmd(input logic [15:0] data, input bit expect_sts, input logic [16:0] sts);
    logic [16:0] word;
    rsp_t        r;
    word = {data, ~^data};
    for (int i = 16; i >= 0; i--) exp_bits.push_back(word[i]);
    drv_total = expect_sts ? 34 : 17;
    drv_sts   = sts;
    pulse_cnt = 0;
    drv_en    = 1'b1;
    r.status  = expect_sts ? sts[16:1] : 16'h0000;
    r.err     = expect_sts ? ~(^sts) : 1'b0;
    r.tmo     = 1'b0;
    exp_rsp.push_back(r);
    issue(data, expect_sts);
  endtask

  task automatic wait_rsp(input string tag, output rsp_t got);
    int   k;
    rsp_t e;
    got = '0;
    k = 0;
    while (!rsp_valid && k < RSP_BUDGET) begin
      @(negedge aclk);
      k++;
    end
    if (k >= RSP_BUDGET) begin
      chk_val({tag, "_rsp_valid_wait"}, 32'd0, 32'd1);
    end else if (exp_rsp.size() == 0) begin
      chk_val({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = exp_rsp.pop_front();
      got = e;
      chk_val({tag, "_status"}, 32'(rsp_status), 32'(e.status));
      chk_val({tag, "_parity_err"}, 32'(rsp_parity_err), 32'(e.err));
      chk_val({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.tmo));
      if (drv_en) chk_val({tag, "_req_pulses"}, 32'(pulse_cnt), 32'(drv_total));
    end
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    @(negedge aclk);
    chk_val({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    chk_val({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stimulus
    rsp_t        r;
    int          k;
    logic [15:0] vec [4];

    repeat (3) @(negedge aclk);
    chk_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_val("rst_req", 32'(esdi_transfer_req), 32'd0);
    chk_val("rst_data", 32'(esdi_command_data), 32'd0);
    chk_val("rst_rsp_fields", {13'd0, rsp_status, rsp_parity_err, rsp_timeout}, 32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Single command, no status; then parity corner words.
    vec[0] = 16'h0001; vec[1] = 16'h0000; vec[2] = 16'hFFFF; vec[3] = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      send_cmd(vec[i], 1'b0, 17'h0);
      wait_rsp($sformatf("nosts%0d", i), r);
      ack_rsp($sformatf("nosts%0d", i));
    end

    // Status reply: good parity, then bad parity.
    send_cmd(16'h1234, 1'b1, {16'hA5C3, 1'b1});
    wait_rsp("sts_good", r);
    ack_rsp("sts_good");
    send_cmd(16'h4321, 1'b1, {16'hA5C3, 1'b0});
    wait_rsp("sts_bad", r);
    ack_rsp("sts_bad");

    // Second request while busy, then hold rsp_ready low for 10 cycles.
    send_cmd(16'h8421, 1'b1, {16'h0F0F, 1'b1});
    repeat (20) @(negedge aclk);
    chk_val("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_data  = 16'hBEEF;
    cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    wait_rsp("hold", r);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk_val($sformatf("hold_rsp_valid%0d", i), 32'(rsp_valid), 32'd1);
      chk_val($sformatf("hold_status%0d", i), 32'(rsp_status), 32'(r.status));
    end
    ack_rsp("hold");
    repeat (5) @(negedge aclk);
    chk_val("hold_no_second_cmd", 32'(busy), 32'd0);

    // Drive never acknowledges.
    drv_en = 1'b0;
`ifdef ESDI_CMD_TIMEOUT_EN
    r.status = 16'h0000; r.err = 1'b0; r.tmo = 1'b1;
    exp_rsp.push_back(r);
    issue(16'h5A5A, 1'b0);
    k = 0;
    while (!esdi_transfer_req && k < 100) begin
      @(negedge aclk);
      k++;
    end
    chk_val("tmo_req_rise", 32'(esdi_transfer_req), 32'd1);
    k = 0;
    while (esdi_transfer_req && k < 300) begin
      k++;
      @(negedge aclk);
    end
    chk_val("tmo_req_high_cycles", 32'(k), 32'(TIMEOUT_CYCLES));
    wait_rsp("tmo", r);
    ack_rsp("tmo");
`else
    issue(16'h5A5A, 1'b0);
    repeat (150) @(negedge aclk);
    chk_val("notmo_req_held", 32'(esdi_transfer_req), 32'd1);
    chk_val("notmo_busy", 32'(busy), 32'd1);
    chk_val("notmo_rsp_valid", 32'(rsp_valid), 32'd0);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
`endif

    // Reset in the middle of bit 7, then a clean command.
    send_cmd(16'hC3A5, 1'b0, 17'h0);
    k = 0;
    while (!(pulse_cnt == 7 && esdi_transfer_req) && k < RSP_BUDGET) begin
      @(negedge aclk);
      k++;
    end
    chk_val("midrst_reach_bit7", 32'(pulse_cnt), 32'd7);
    aresetn = 1'b0;
    #1;
    chk_val("midrst_req_async", 32'(esdi_transfer_req), 32'd0);
    chk_val("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_bits.delete();
    exp_rsp.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    chk_val("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    send_cmd(16'h8001, 1'b0, 17'h0);
    wait_rsp("postrst", r);
    ack_rsp("postrst");

    chk_val("leftover_bits", 32'(exp_bits.size()), 32'd0);
    chk_val("leftover_rsp", 32'(exp_rsp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
